qed_dup_buffer: RTL and testbench
=================================

// Module: qed_dup_buffer
// PURPOSE
// - QED original/duplicate issue buffer; sits between instruction fetch and the QED instruction
//   rewriter. Normal mode: fetched instructions pass through and are recorded; dup mode: the
//   recorded instructions are replayed in order, flagged as duplicates.
// - The downstream rewriter remaps registers/immediates of flagged entries; this block only
//   sequences the original/duplicate streams and back-pressures fetch.
// PARAMETERS
// - DEPTH    16  max originals recorded before a forced replay (>=2; need not be power of 2)
// - PTR_W    $clog2(DEPTH)    read/write pointer width (derived)
// - CNT_W    $clog2(DEPTH+1)  occupancy counter width (derived)
// PORTS
// - clk_i          in   1      clock, rising edge
// - rst_ni         in   1      asynchronous reset, active-low
// - ena_i          in   1      QED enable; 0 = transparent pass-through, nothing recorded
// - exec_dup_i     in   1      request replay of everything recorded so far
// - ifu_instr_i    in   32     instruction from fetch
// - ifu_valid_i    in   1      ifu_instr_i valid
// - ifu_ready_o    out  1      buffer accepts ifu_instr_i this cycle
// - dec_ready_i    in   1      downstream (rewriter/decode) accepts qic_instr_o
// - qic_instr_o    out  32     instruction to rewriter (qic_qimux_instruction)
// - qic_valid_o    out  1      qic_instr_o valid
// - qic_is_dup_o   out  1      1 = replayed duplicate, rewriter must remap it
// - qed_cnt_o      out  CNT_W  originals recorded and not yet replayed
// - orig_done_o    out  1      1-cycle pulse: last duplicate of a replay batch accepted
// BEHAVIOUR
// - Reset (rst_ni=0, async): state=ORIG, wr_ptr=0, rd_ptr=0, count=0, orig_done_o=0.
//   While rst_ni=0, qic_valid_o=0 and ifu_ready_o=0 regardless of inputs.
// - Handshake: a transfer occurs on a rising edge with valid&ready. Ready never depends on
//   valid. In ORIG, instr/valid are driven combinationally from fetch (0-cycle latency).
// - ORIG state:
//   qic_instr_o=ifu_instr_i; qic_is_dup_o=0; room = !ena_i | (count<DEPTH)
//   qic_valid_o = ifu_valid_i & room; ifu_ready_o = dec_ready_i & room
//   On transfer with ena_i=1: buf[wr_ptr]<=ifu_instr_i; wr_ptr wraps DEPTH-1 -> 0; count+1.
//   With ena_i=0: nothing is recorded; count holds.
// - ORIG->DUP at a clock edge when ena_i=1 and (count_next==DEPTH or (exec_dup_i and count_next!=0)),
//   where count_next includes a transfer occurring on the same edge. exec_dup_i with count_next==0
//   is ignored (stay ORIG, no pulse).
// - DUP state:
//   qic_instr_o=buf[rd_ptr]; qic_valid_o=1; qic_is_dup_o=1; ifu_ready_o=0 (fetch stalled).
//   On transfer: rd_ptr wraps DEPTH-1 -> 0; count-1. The transfer that brings count to 0 moves the
//   state to ORIG and pulses orig_done_o for exactly one cycle (the cycle after that edge).
// - ena_i and exec_dup_i are sampled only in ORIG; a replay in progress always completes.
// - Pointers: wr_ptr-rd_ptr (mod DEPTH) == count in ORIG at all times; no overflow is possible,
//   because room=0 at count==DEPTH blocks fetch until the forced replay.
// - qed_cnt_o=count (registered). The buffer array is not reset; only its pointers are.
// - Mid-operation reset: DUP aborts immediately and recorded entries are discarded; the first
//   cycle after release is ORIG with count=0.
// TESTING
// - Reset: rst_ni=0 with ifu_valid_i=1, dec_ready_i=1 -> qic_valid_o=0, ifu_ready_o=0, qed_cnt_o=0.
// - Pass-through: ena_i=0, stream 0x00500093, 0x00108133 -> both appear on qic_instr_o with
//   qic_is_dup_o=0; qed_cnt_o stays 0.
// - Record/replay: ena_i=1, issue 3 instrs (0x00500093, 0x00108133, 0x0020A023), then exec_dup_i=1
//   -> ifu_ready_o=0; the same 3 words come out in order with qic_is_dup_o=1; orig_done_o pulses
//   once; then back to ORIG.
// - Full: DEPTH=16, 16 transfers with no exec_dup_i -> replay starts the next cycle; the 17th
//   fetch word is held (ifu_ready_o=0) until all 16 duplicates are accepted, then it is accepted.
// - Back-pressure/simultaneous: in DUP, toggle dec_ready_i 1,0,1 -> rd_ptr advances only on
//   ready=1, qic_instr_o is stable while stalled; a transfer plus exec_dup_i on the same edge
//   includes that instr in the batch.
// - Reset mid-DUP after 2 of 5 duplicates -> next cycle ORIG, qed_cnt_o=0, no orig_done_o pulse.

Source files
------------

// File: rtl/qed_dup_buffer_if.sv
// Fetch-side, rewriter-side and control signals of the QED original/duplicate issue buffer.
interface qed_dup_buffer_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             ena;
    logic             exec_dup;
    logic [31:0]      ifu_instr;
    logic             ifu_valid;
    logic             ifu_ready;
    logic             dec_ready;
    logic [31:0]      qic_instr;
    logic             qic_valid;
    logic             qic_is_dup;
    logic [CNT_W-1:0] qed_cnt;
    logic             orig_done;

    modport master (
        output ena, exec_dup, ifu_instr, ifu_valid, dec_ready,
        input  ifu_ready, qic_instr, qic_valid, qic_is_dup, qed_cnt, orig_done
    );

    modport slave (
        input  ena, exec_dup, ifu_instr, ifu_valid, dec_ready,
        output ifu_ready, qic_instr, qic_valid, qic_is_dup, qed_cnt, orig_done
    );
endinterface

// File: rtl/qed_dup_buffer.sv
// Records fetched instructions, then replays them in order as flagged duplicates.
// Latency: 0 cycles pass-through in ORIG; replay reads the registered buffer head.
// Backpressure: fetch is stalled while replaying or when the record buffer is full.
module qed_dup_buffer #(
    parameter int DEPTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    qed_dup_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {ST_ORIG, ST_DUP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             done_q, done_d;
    logic [31:0]      mem [DEPTH];

    logic             room, valid, ready, xfer, rec, pop;
    logic [31:0]      instr;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        room       = !bus.ena || (count < CNT_W'(DEPTH));
        instr      = bus.ifu_instr;
        valid      = 1'b0;
        ready      = 1'b0;
        state_d    = state_q;
        done_d     = 1'b0;
        if (state_q == ST_ORIG) begin
            valid = rst_n && bus.ifu_valid && room;
            ready = rst_n && bus.dec_ready && room;
        end else begin
            instr = mem[rd_ptr];
            valid = rst_n;
        end
        xfer       = valid && bus.dec_ready;
        rec        = (state_q == ST_ORIG) && xfer && bus.ena;
        pop        = (state_q == ST_DUP) && xfer;
        count_next = count + CNT_W'(rec) - CNT_W'(pop);
        if (state_q == ST_ORIG) begin
            // A word accepted on the same edge as exec_dup joins the batch.
            if (bus.ena && ((count_next == CNT_W'(DEPTH)) ||
                            (bus.exec_dup && (count_next != '0))))
                state_d = ST_DUP;
        end else if (pop && (count_next == '0)) begin
            state_d = ST_ORIG;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ORIG;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_next;
            done_q  <= done_d;
            if (rec) wr_ptr <= wrap_inc(wr_ptr);
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
        end
    end

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (rec) mem[wr_ptr] <= bus.ifu_instr;
    end

    assign bus.qic_instr  = instr;
    assign bus.qic_valid  = valid;
    assign bus.qic_is_dup = (state_q == ST_DUP);
    assign bus.ifu_ready  = ready;
    assign bus.qed_cnt    = count;
    assign bus.orig_done  = done_q;
endmodule

// File: tb/tb_qed_dup_buffer.sv
// Randomized and directed bench for qed_dup_buffer with a queue-based reference model and scoreboard.
module tb_qed_dup_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qed_dup_buffer_if #(.DEPTH(DEPTH)) bus();

    qed_dup_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rec_q[$];
    logic [32:0] exp_q[$];
    bit          m_dup  = 1'b0;
    bit          m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: recorded words are a queue; replay drains its head.
    task automatic model_step();
        bit room, ev, er;
        if (!rst_n) begin
            chk("rst_valid", 32'(bus.qic_valid), 32'd0);
            chk("rst_ready", 32'(bus.ifu_ready), 32'd0);
            chk("rst_cnt",   32'(bus.qed_cnt),   32'd0);
            chk("rst_done",  32'(bus.orig_done), 32'd0);
            rec_q.delete();
            m_dup  = 1'b0;
            m_done = 1'b0;
            return;
        end
        chk("qed_cnt",   32'(bus.qed_cnt),   32'(rec_q.size()));
        chk("orig_done", 32'(bus.orig_done), 32'(m_done));
        m_done = 1'b0;
        if (!m_dup) begin
            room = !bus.ena || (rec_q.size() < DEPTH);
            ev   = bus.ifu_valid && room;
            er   = bus.dec_ready && room;
            chk("orig_valid", 32'(bus.qic_valid), 32'(ev));
            chk("orig_ready", 32'(bus.ifu_ready), 32'(er));
            if (ev) begin
                chk("orig_instr", bus.qic_instr, bus.ifu_instr);
                chk("orig_flag",  32'(bus.qic_is_dup), 32'd0);
            end
            if (ev && bus.dec_ready) begin
                exp_q.push_back({1'b0, bus.ifu_instr});
                if (bus.ena) rec_q.push_back(bus.ifu_instr);
            end
            if (bus.ena && (rec_q.size() == DEPTH || (bus.exec_dup && rec_q.size() != 0)))
                m_dup = 1'b1;
        end else begin
            chk("dup_valid", 32'(bus.qic_valid), 32'd1);
            chk("dup_ready", 32'(bus.ifu_ready), 32'd0);
            chk("dup_instr", bus.qic_instr, rec_q[0]);
            if (bus.dec_ready) begin
                exp_q.push_back({1'b1, rec_q[0]});
                void'(rec_q.pop_front());
                if (rec_q.size() == 0) begin
                    m_dup  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard monitor: pops one expectation per presented transfer.
    always @(negedge clk) begin
        logic [32:0] e;
        #1;
        if (rst_n && bus.qic_valid && bus.dec_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_unexpected: got %h with no expected word", bus.qic_instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", bus.qic_instr, e[31:0]);
                chk("sb_flag",  32'(bus.qic_is_dup), 32'(e[32]));
            end
        end
    end

    task automatic step(input bit en, input bit ex, input logic [31:0] ins,
                        input bit v, input bit dr);
        bus.ena       = en;
        bus.exec_dup  = ex;
        bus.ifu_instr = ins;
        bus.ifu_valid = v;
        bus.dec_ready = dr;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ena = 1'b0; bus.exec_dup = 1'b0; bus.ifu_instr = '0;
        bus.ifu_valid = 1'b1; bus.dec_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reset holds handshakes low even with valid/ready asserted.
        step(1'b1, 1'b1, 32'h00500093, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h00108133, 1'b1, 1'b1);
        rst_n = 1'b1;

        step(1'b0, 1'b0, 32'h00500093, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h00108133, 1'b1, 1'b1);

        step(1'b1, 1'b0, 32'h00500093, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h00108133, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0020A023, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'hDEAD0000, 1'b1, 1'b1);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h1000 + 32'(i), 1'b1, 1'b1);
        for (int i = 0; i < DEPTH + 3; i++) step(1'b0, 1'b0, 32'h00001017, 1'b1, 1'b1);

        step(1'b1, 1'b0, 32'hA1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'hA3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hB0 + 32'(i), 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'hC0, 1'b1, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), $urandom(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
